// File: rtl/fifo_wr_arb_if.sv
// fifo_wr_arb_if: requester handshake and FIFO write-port bundle (master = arbiter, slave = requesters/FIFO)
interface fifo_wr_arb_if #(parameter int NREQ = 4, parameter int DSIZE = 8);
  logic [NREQ-1:0] req_valid;
  logic [NREQ*DSIZE-1:0] req_data;
  logic [NREQ-1:0] req_last;
  logic [NREQ-1:0] req_ready;
  logic wfull;
  logic winc;
  logic [DSIZE-1:0] wdata;
  logic [NREQ-1:0] grant;
  logic busy;
  modport master(
    input req_valid, req_data, req_last, wfull,
    output req_ready, winc, wdata, grant, busy
  );
  modport slave(
    output req_valid, req_data, req_last, wfull,
    input req_ready, winc, wdata, grant, busy
  );
endinterface

// File: rtl/fifo_wr_arb.sv
// fifo_wr_arb: packet-locked round-robin arbiter for one FIFO write port (ports wclk, wrst_n, bus; FIFO_WR_ARB_STALLCNT_EN adds stall_cnt)
module fifo_wr_arb #(
  parameter int NREQ = 4,
  parameter int DSIZE = 8
) (
  input logic wclk,
  input logic wrst_n,
  fifo_wr_arb_if.master bus
`ifdef FIFO_WR_ARB_STALLCNT_EN
  ,
  output logic [15:0] stall_cnt
`endif
);
  localparam int IW = $clog2(NREQ);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] LOCK = 1'b1;
  logic [0:0] state_q, state_d;
  logic [IW-1:0] gidx_q, gidx_d, last_gidx_q, last_gidx_d;
  logic [IW-1:0] ptr, idx, pick;
  logic [NREQ-1:0] cand;
  logic lock, fire, eop, any_cand;
  assign lock = state_q == LOCK;
  assign fire = lock && bus.req_valid[gidx_q] && !bus.wfull;
  assign eop = fire && bus.req_last[gidx_q];
  assign any_cand = |cand;
  always_comb begin
    ptr = lock ? gidx_q : last_gidx_q;
    cand = bus.req_valid;
    if (lock) cand[gidx_q] = 1'b0;
    pick = '0;
    idx = '0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = IW'((int'(ptr) + k) % NREQ);
      if (cand[idx]) pick = idx;
    end
  end
  always_comb begin
    state_d = !lock ? (any_cand ? LOCK : IDLE) : (eop && !any_cand) ? IDLE : LOCK;
    gidx_d = ((!lock || eop) && any_cand) ? pick : gidx_q;
    last_gidx_d = eop ? gidx_q : last_gidx_q;
  end
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state_q <= IDLE;
      gidx_q <= '0;
      last_gidx_q <= IW'(NREQ - 1);
    end else begin
      state_q <= state_d;
      gidx_q <= gidx_d;
      last_gidx_q <= last_gidx_d;
    end
  end
  always_comb begin
    bus.winc = fire;
    bus.busy = lock;
    bus.grant = lock ? NREQ'(1) << gidx_q : '0;
    bus.req_ready = fire ? NREQ'(1) << gidx_q : '0;
    bus.wdata = lock ? bus.req_data[gidx_q*DSIZE +: DSIZE] : '0;
  end
`ifdef FIFO_WR_ARB_STALLCNT_EN
  logic [15:0] stall_q, stall_d;
  always_comb stall_d = (lock && bus.req_valid[gidx_q] && bus.wfull && stall_q != 16'hFFFF) ? stall_q + 16'd1 : stall_q;
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) stall_q <= '0;
    else stall_q <= stall_d;
  end
  assign stall_cnt = stall_q;
`endif
endmodule

// File: tb/tb_fifo_wr_arb.sv
// tb_fifo_wr_arb: scoreboard bench for fifo_wr_arb against a packet-queue reference model
module tb_fifo_wr_arb;
  localparam int NREQ = 4;
  localparam int DSIZE = 8;
  typedef struct packed {
    logic winc;
    logic [NREQ-1:0] rdy;
    logic [NREQ-1:0] g;
    logic busy;
  } ctrl_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int tests = 0;
  int fails = 0;
  logic in_rst = 1'b1;
  logic [DSIZE:0] pq [NREQ][$];
  logic [DSIZE-1:0] expw [$];
  ctrl_t expc [$];
  int owner = -1;
  int rr = NREQ - 1;
  logic [15:0] stall_e = '0;
  fifo_wr_arb_if #(.NREQ(NREQ), .DSIZE(DSIZE)) bus();
`ifdef FIFO_WR_ARB_STALLCNT_EN
  logic [15:0] stall_cnt;
`endif
  fifo_wr_arb #(.NREQ(NREQ), .DSIZE(DSIZE)) dut (
    .wclk(clk),
    .wrst_n(rst_n),
    .bus(bus)
`ifdef FIFO_WR_ARB_STALLCNT_EN
    ,
    .stall_cnt(stall_cnt)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask
  function automatic int next_owner(input logic [NREQ-1:0] v, input int from, input int excl);
    for (int k = 1; k <= NREQ; k++) begin
      int i;
      i = (from + k) % NREQ;
      if (i != excl && v[i]) return i;
    end
    return -1;
  endfunction
  task automatic add_pkt(input int r, input int len, input logic [DSIZE-1:0] base);
    for (int b = 0; b < len; b++) pq[r].push_back({b == len - 1, base + DSIZE'(b)});
  endtask
  task automatic cycle(input logic [NREQ-1:0] vmask, input logic full);
    logic [NREQ-1:0] v, l;
    logic [NREQ*DSIZE-1:0] d;
    ctrl_t e;
    @(posedge clk);
    #1;
    v = '0;
    l = '0;
    d = '0;
    for (int i = 0; i < NREQ; i++)
      if (pq[i].size() > 0) begin
        v[i] = vmask[i];
        l[i] = pq[i][0][DSIZE];
        d[i*DSIZE +: DSIZE] = pq[i][0][DSIZE-1:0];
      end
    bus.req_valid = v;
    bus.req_last = l;
    bus.req_data = d;
    bus.wfull = full;
    e = '0;
    if (owner < 0) owner = next_owner(v, rr, -1);
    else begin
      e.busy = 1'b1;
      e.g[owner] = 1'b1;
      if (v[owner] && full && stall_e != 16'hFFFF) stall_e++;
      if (v[owner] && !full) begin
        e.winc = 1'b1;
        e.rdy[owner] = 1'b1;
        expw.push_back(pq[owner][0][DSIZE-1:0]);
        void'(pq[owner].pop_front());
        if (l[owner]) begin
          rr = owner;
          owner = next_owner(v, owner, owner);
        end
      end
    end
    expc.push_back(e);
    in_rst = 1'b0;
  endtask
  always @(negedge clk) begin
    if (!in_rst) begin
      if (expc.size() == 0) chk("ctrl_queue_empty", 32'd1, 32'd0);
      else begin
        ctrl_t e;
        e = expc.pop_front();
        chk("winc", 32'(bus.winc), 32'(e.winc));
        chk("req_ready", 32'(bus.req_ready), 32'(e.rdy));
        chk("grant", 32'(bus.grant), 32'(e.g));
        chk("busy", 32'(bus.busy), 32'(e.busy));
        if (!e.busy) chk("wdata_idle", 32'(bus.wdata), 32'd0);
      end
      if (bus.winc) begin
        if (expw.size() == 0) chk("unexpected_write", 32'(bus.wdata), 32'hFFFF_FFFF);
        else chk("wdata", 32'(bus.wdata), 32'(expw.pop_front()));
      end
    end
  end
  task automatic check_stall();
`ifdef FIFO_WR_ARB_STALLCNT_EN
    chk("stall_cnt", 32'(stall_cnt), 32'(stall_e));
`endif
  endtask
  initial begin
    bus.req_valid = '0;
    bus.req_last = '0;
    bus.req_data = '0;
    bus.wfull = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_grant", 32'(bus.grant), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_winc", 32'(bus.winc), 32'd0);
    chk("rst_wdata", 32'(bus.wdata), 32'd0);
    chk("rst_ready", 32'(bus.req_ready), 32'd0);
    check_stall();
    rst_n = 1'b1;
    add_pkt(0, 3, 8'hA1);
    repeat (5) cycle('1, 1'b0);
    for (int i = 0; i < NREQ; i++) add_pkt(i, 2, DSIZE'(8'h10 * (i + 1)));
    repeat (10) cycle('1, 1'b0);
    add_pkt(0, 4, 8'hC1);
    cycle('1, 1'b0);
    cycle('1, 1'b0);
    repeat (3) cycle('1, 1'b1);
    repeat (4) cycle('1, 1'b0);
    check_stall();
    add_pkt(2, 3, 8'hD1);
    add_pkt(1, 2, 8'hE1);
    cycle(4'b0100, 1'b0);
    cycle(4'b0110, 1'b0);
    repeat (2) cycle(4'b0010, 1'b0);
    repeat (4) cycle(4'b0110, 1'b0);
    cycle(4'b0000, 1'b0);
    add_pkt(1, 2, 8'h51);
    add_pkt(1, 2, 8'h61);
    cycle(4'b0010, 1'b0);
    add_pkt(3, 2, 8'h71);
    repeat (8) cycle('1, 1'b0);
    add_pkt(0, 4, 8'h81);
    repeat (3) cycle('1, 1'b0);
    @(posedge clk);
    #1;
    in_rst = 1'b1;
    rst_n = 1'b0;
    #2;
    chk("arst_winc", 32'(bus.winc), 32'd0);
    chk("arst_grant", 32'(bus.grant), 32'd0);
    chk("arst_busy", 32'(bus.busy), 32'd0);
    chk("arst_ready", 32'(bus.req_ready), 32'd0);
    for (int i = 0; i < NREQ; i++) pq[i].delete();
    expw.delete();
    expc.delete();
    owner = -1;
    rr = NREQ - 1;
    stall_e = '0;
    bus.req_valid = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = NREQ - 1; i >= 0; i--) add_pkt(i, 1, DSIZE'(8'h90 + i));
    repeat (6) cycle('1, 1'b0);
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NREQ; i++)
        if (pq[i].size() == 0 && $urandom_range(0, 3) == 0) add_pkt(i, $urandom_range(1, 4), DSIZE'($urandom));
      cycle(NREQ'($urandom), $urandom_range(0, 3) == 0);
    end
    for (int n = 0; n < 200; n++) begin
      int pend;
      pend = 0;
      for (int i = 0; i < NREQ; i++) pend += pq[i].size();
      if (pend == 0) break;
      cycle('1, 1'b0);
    end
    repeat (2) cycle('0, 1'b0);
    @(negedge clk);
    #1;
    chk("writes_outstanding", 32'(expw.size()), 32'd0);
    check_stall();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
